alu_uart_ctrl: RTL and testbench

ALU_UART_CTRL -- requirements
Module: alu_uart_ctrl

---
 rtl/alu_uart_ctrl.sv | 140 ++++++++++++++
 tb/tb_alu_uart_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_uart_ctrl.sv
// Sequencer between a byte-oriented UART and a combinational ALU: collects
// operand A, operand B and an opcode, runs one ALU cycle, then sends the result.
//
//   state   | meaning
//   WAIT_A  | idle, next received byte is operand A
//   WAIT_B  | next received byte is operand B
//   WAIT_OP | next received byte is the opcode (validated)
//   EXEC    | single cycle, ALU result captured, TX start issued
//   WAIT_TX | result held on o_tx_data until the UART reports completion
module alu_uart_ctrl #(
    parameter int SIZE    = 8,
    parameter int OP_BITS = 6
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [SIZE-1:0]    i_rx_data,
    input  logic               i_rx_done,
    input  logic               i_tx_done,
    input  logic [SIZE-1:0]    i_alu_res,
    input  logic               i_alu_carry,
    output logic [SIZE-1:0]    o_alu_a,
    output logic [SIZE-1:0]    o_alu_b,
    output logic [OP_BITS-1:0] o_alu_op,
    output logic [SIZE-1:0]    o_tx_data,
    output logic               o_tx_start,
    output logic               o_carry,
    output logic               o_busy,
    output logic               o_error
);

    typedef enum logic [2:0] {
        WAIT_A,
        WAIT_B,
        WAIT_OP,
        EXEC,
        WAIT_TX
    } state_t;

    localparam logic [OP_BITS-1:0] OP_ADD = OP_BITS'('h20);
    localparam logic [OP_BITS-1:0] OP_SUB = OP_BITS'('h22);
    localparam logic [OP_BITS-1:0] OP_AND = OP_BITS'('h24);
    localparam logic [OP_BITS-1:0] OP_OR  = OP_BITS'('h25);
    localparam logic [OP_BITS-1:0] OP_XOR = OP_BITS'('h26);
    localparam logic [OP_BITS-1:0] OP_SRA = OP_BITS'('h03);
    localparam logic [OP_BITS-1:0] OP_SRL = OP_BITS'('h02);
    localparam logic [OP_BITS-1:0] OP_NOR = OP_BITS'('h27);

    state_t             state;
    state_t             state_next;
    logic               load_a;
    logic               load_b;
    logic               load_op;
    logic               latch_res;
    logic               reject;
    logic               op_valid;
    logic [OP_BITS-1:0] op_field;

    assign op_field = i_rx_data[OP_BITS-1:0];

    // A byte with any bit set above the opcode field is never a valid opcode.
    always_comb begin
        op_valid = 1'b0;
        if ((i_rx_data >> OP_BITS) == '0) begin
            case (op_field)
                OP_ADD, OP_SUB, OP_AND, OP_OR,
                OP_XOR, OP_SRA, OP_SRL, OP_NOR: op_valid = 1'b1;
                default:                        op_valid = 1'b0;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        load_a     = 1'b0;
        load_b     = 1'b0;
        load_op    = 1'b0;
        latch_res  = 1'b0;
        reject     = 1'b0;
        case (state)
            WAIT_A: begin
                if (i_rx_done) begin
                    load_a     = 1'b1;
                    state_next = WAIT_B;
                end
            end
            WAIT_B: begin
                if (i_rx_done) begin
                    load_b     = 1'b1;
                    state_next = WAIT_OP;
                end
            end
            WAIT_OP: begin
                if (i_rx_done) begin
                    if (op_valid) begin
                        load_op    = 1'b1;
                        state_next = EXEC;
                    end else begin
                        reject     = 1'b1;
                        state_next = WAIT_A;
                    end
                end
            end
            EXEC: begin
                latch_res  = 1'b1;
                state_next = WAIT_TX;
            end
            WAIT_TX: begin
                if (i_tx_done) state_next = WAIT_A;
            end
            default: state_next = WAIT_A;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= WAIT_A;
            o_alu_a    <= '0;
            o_alu_b    <= '0;
            o_alu_op   <= '0;
            o_tx_data  <= '0;
            o_carry    <= 1'b0;
            o_tx_start <= 1'b0;
            o_error    <= 1'b0;
        end else begin
            state      <= state_next;
            o_tx_start <= latch_res;
            o_error    <= reject;
            if (load_a)  o_alu_a  <= i_rx_data;
            if (load_b)  o_alu_b  <= i_rx_data;
            if (load_op) o_alu_op <= op_field;
            if (latch_res) begin
                o_tx_data <= i_alu_res;
                o_carry   <= i_alu_carry;
            end
        end
    end

    assign o_busy = (state == EXEC) || (state == WAIT_TX);

endmodule

// File: tb/tb_alu_uart_ctrl.sv
// Self-checking bench for alu_uart_ctrl: directed scenarios followed by random
// transactions, compared against an arithmetic reference model of the sequence.
module tb_alu_uart_ctrl;

    logic       i_clk = 1'b0;
    logic       i_reset = 1'b1;
    logic [7:0] i_rx_data = 8'h00;
    logic       i_rx_done = 1'b0;
    logic       i_tx_done = 1'b0;
    logic [7:0] i_alu_res;
    logic       i_alu_carry;
    logic [7:0] o_alu_a;
    logic [7:0] o_alu_b;
    logic [5:0] o_alu_op;
    logic [7:0] o_tx_data;
    logic       o_tx_start;
    logic       o_carry;
    logic       o_busy;
    logic       o_error;

    int tests = 0;
    int fails = 0;

    logic [7:0] exp_a = 8'h00;
    logic [7:0] exp_b = 8'h00;
    logic [5:0] exp_op = 6'h00;
    logic [7:0] exp_tx = 8'h00;
    logic       exp_carry = 1'b0;
    logic [7:0] tx_seen = 8'h00;

    alu_uart_ctrl #(.SIZE(8), .OP_BITS(6)) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_rx_data  (i_rx_data),
        .i_rx_done  (i_rx_done),
        .i_tx_done  (i_tx_done),
        .i_alu_res  (i_alu_res),
        .i_alu_carry(i_alu_carry),
        .o_alu_a    (o_alu_a),
        .o_alu_b    (o_alu_b),
        .o_alu_op   (o_alu_op),
        .o_tx_data  (o_tx_data),
        .o_tx_start (o_tx_start),
        .o_carry    (o_carry),
        .o_busy     (o_busy),
        .o_error    (o_error)
    );

    always #5 i_clk = ~i_clk;

    // Stand-in combinational ALU driven from the controller's registered operands;
    // shifts move operand A by one place.
    always_comb begin
        i_alu_res   = 8'h00;
        i_alu_carry = 1'b0;
        case (o_alu_op)
            6'h20: {i_alu_carry, i_alu_res} = {1'b0, o_alu_a} + {1'b0, o_alu_b};
            6'h22: {i_alu_carry, i_alu_res} = {1'b0, o_alu_a} - {1'b0, o_alu_b};
            6'h24: i_alu_res = o_alu_a & o_alu_b;
            6'h25: i_alu_res = o_alu_a | o_alu_b;
            6'h26: i_alu_res = o_alu_a ^ o_alu_b;
            6'h27: i_alu_res = ~(o_alu_a | o_alu_b);
            6'h03: i_alu_res = {o_alu_a[7], o_alu_a[7:1]};
            6'h02: i_alu_res = {1'b0, o_alu_a[7:1]};
            default: ;
        endcase
    end

    function automatic bit is_valid(input logic [7:0] op);
        logic [7:0] ops [8] = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h03, 8'h02, 8'h27};
        foreach (ops[i]) if (ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    // Expected {carry, result} from plain integer arithmetic on the sent bytes.
    function automatic logic [8:0] model_alu(input logic [7:0] a, b, op);
        int ia = int'(a);
        int ib = int'(b);
        int r  = 0;
        bit c  = 1'b0;
        case (op)
            8'h20: begin r = ia + ib; c = (r > 255); r = r % 256; end
            8'h22: begin r = ia - ib; c = (r < 0); r = (r + 256) % 256; end
            8'h24: r = int'(a & b);
            8'h25: r = int'(a | b);
            8'h26: r = int'(a ^ b);
            8'h27: r = 255 - int'(a | b);
            8'h03: r = ia / 2 + ((ia >= 128) ? 128 : 0);
            8'h02: r = ia / 2;
            default: r = 0;
        endcase
        return {c, 8'(r)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send(input logic [7:0] v);
        i_rx_data = v;
        i_rx_done = 1'b1;
        tick();
        i_rx_done = 1'b0;
        i_rx_data = 8'($urandom);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_a"}, o_alu_a, 8'h00);
        chk({tag, "_b"}, o_alu_b, 8'h00);
        chk({tag, "_op"}, o_alu_op, 6'h00);
        chk({tag, "_tx"}, o_tx_data, 8'h00);
        chk({tag, "_carry"}, o_carry, 1'b0);
        chk({tag, "_start"}, o_tx_start, 1'b0);
        chk({tag, "_err"}, o_error, 1'b0);
        chk({tag, "_busy"}, o_busy, 1'b0);
    endtask

    // One full A/B/OP exchange. stray: tx_done pulses while collecting operands;
    // junk: rx bytes arrive while busy; both: last rx coincides with tx_done.
    task automatic run_txn(input logic [7:0] a, b, op, input bit stray, junk, both,
                           input int gap);
        logic [8:0] m;
        if (stray) begin
            i_tx_done = 1'b1; tick(); i_tx_done = 1'b0;
            chk("stray_tx_idle", o_busy, 1'b0);
        end
        send(a);
        exp_a = a;
        chk("load_a", o_alu_a, exp_a);
        chk("busy_wait_b", o_busy, 1'b0);
        if (stray) begin
            i_tx_done = 1'b1; tick(); i_tx_done = 1'b0;
        end
        send(b);
        exp_b = b;
        chk("load_b", o_alu_b, exp_b);
        chk("hold_a_b", o_alu_a, exp_a);
        send(op);
        if (is_valid(op)) begin
            exp_op = op[5:0];
            m = model_alu(a, b, op);
            {exp_carry, exp_tx} = m;
            chk("load_op", o_alu_op, exp_op);
            chk("busy_exec", o_busy, 1'b1);
            chk("no_start_exec", o_tx_start, 1'b0);
            chk("no_err_valid", o_error, 1'b0);
            if (junk) begin
                i_rx_data = 8'($urandom); i_rx_done = 1'b1;
            end
            tick();
            i_rx_done = 1'b0;
            tx_seen = o_tx_data;
            chk("tx_start_pulse", o_tx_start, 1'b1);
            chk("tx_data", o_tx_data, exp_tx);
            chk("carry", o_carry, exp_carry);
            chk("busy_tx", o_busy, 1'b1);
            for (int g = 0; g <= gap; g++) begin
                if (junk) send(8'($urandom)); else tick();
                chk("start_single", o_tx_start, 1'b0);
                chk("tx_hold", o_tx_data, exp_tx);
                chk("busy_hold", o_busy, 1'b1);
                chk("a_hold_busy", o_alu_a, exp_a);
                chk("op_hold_busy", o_alu_op, exp_op);
            end
            i_tx_done = 1'b1;
            if (both) begin
                i_rx_data = 8'($urandom); i_rx_done = 1'b1;
            end
            tick();
            i_tx_done = 1'b0;
            i_rx_done = 1'b0;
            chk("idle_after_tx", o_busy, 1'b0);
            chk("a_after_tx", o_alu_a, exp_a);
        end else begin
            chk("err_pulse", o_error, 1'b1);
            chk("op_unchanged", o_alu_op, exp_op);
            chk("busy_err", o_busy, 1'b0);
            chk("no_start_err", o_tx_start, 1'b0);
            tick();
            chk("err_one_cycle", o_error, 1'b0);
            chk("no_start_err2", o_tx_start, 1'b0);
        end
    endtask

    initial begin
        logic [7:0] ra, rb, rop;
        logic [7:0] ops [8] = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h03, 8'h02, 8'h27};

        tick(); tick();
        i_reset = 1'b0;
        check_zero("reset");

        run_txn(8'h05, 8'h03, 8'h20, 0, 0, 0, 0);
        chk("add_0x08", tx_seen, 8'h08);
        run_txn(8'h05, 8'h07, 8'h22, 0, 0, 0, 3);
        chk("sub_0xfe", tx_seen, 8'hFE);
        run_txn(8'h0F, 8'hF0, 8'h3F, 0, 0, 0, 0);
        run_txn(8'h0F, 8'hF0, 8'h60, 0, 0, 0, 0);
        run_txn(8'h0F, 8'hF0, 8'h25, 0, 0, 0, 0);
        chk("or_0xff", tx_seen, 8'hFF);
        run_txn(8'h12, 8'h34, 8'h26, 1, 1, 0, 2);
        run_txn(8'h9A, 8'h21, 8'h27, 0, 1, 1, 1);

        // Reset while waiting for the opcode, alongside rx/tx strobes.
        send(8'h11);
        send(8'h22);
        i_reset = 1'b1; i_rx_done = 1'b1; i_tx_done = 1'b1; i_rx_data = 8'h20;
        tick();
        i_reset = 1'b0; i_rx_done = 1'b0; i_tx_done = 1'b0;
        exp_a = 8'h00; exp_b = 8'h00; exp_op = 6'h00;
        check_zero("rst_wait_op");
        run_txn(8'h80, 8'h00, 8'h03, 0, 0, 0, 0);
        chk("sra_0xc0", tx_seen, 8'hC0);

        // Reset during EXEC abandons the transaction without a start pulse.
        send(8'h44);
        send(8'h55);
        send(8'h20);
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        exp_a = 8'h00; exp_b = 8'h00; exp_op = 6'h00;
        check_zero("rst_exec");
        tick();
        chk("rst_exec_no_start", o_tx_start, 1'b0);

        for (int n = 0; n < 60; n++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            if ($urandom_range(3, 0) != 0) rop = ops[$urandom_range(7, 0)];
            else rop = 8'($urandom);
            run_txn(ra, rb, rop, bit'($urandom_range(1, 0)), bit'($urandom_range(1, 0)),
                    bit'($urandom_range(1, 0)), int'($urandom_range(3, 0)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
